// File: rtl/tc_timer_if.sv
// tc_timer_if: CPU data-bus view of the timer/counter.
// Signals: addr (byte address), byteen (write strobes), wdata, rdata.
interface tc_timer_if;
  logic [31:0] addr;
  logic [3:0]  byteen;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (
    output addr,
    output byteen,
    output wdata,
    input  rdata
  );

  modport slave (
    input  addr,
    input  byteen,
    input  wdata,
    output rdata
  );
endinterface

// File: rtl/tc_timer.sv
// tc_timer: memory-mapped countdown timer with one-shot / auto-reload
// modes and a masked interrupt line.
// Ports: clk, reset (async, active-high), bus (tc_timer_if.slave:
//   addr, byteen, wdata in; combinational rdata out), irq out.
// Register map (addr[3:2]): 0 CTRL {IM,MODE[1:0],EN}, 1 PRESET,
//   2 COUNT (read-only), 3 PRESCALE when TC_PRESCALE_EN is defined,
//   otherwise reserved (reads 0).
// Optional macro TC_PRESCALE_EN: divides the count tick by PRESCALE+1.
module tc_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic       clk,
  input  logic       reset,
  tc_timer_if.slave  bus,
  output logic       irq
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_CNT,
    S_INT
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_ctrl;
  logic [31:0] r_preset;
  logic [31:0] r_count;
  logic        r_irq_flag;

  logic [31:0] w_count_nxt;
  logic        w_fire;
  logic        w_exit1;
  logic        w_tick;
  logic        w_hit;
  logic [1:0]  w_sel;
  logic        w_wr;
  logic        w_wr_ctrl;
  logic        w_wr_pre;
  logic        w_en;
  logic        w_mode1;
  logic [31:0] w_pre_merged;
  logic        w_unused;

`ifdef TC_PRESCALE_EN
  logic [15:0] r_prescale;
  logic [15:0] r_pre_cnt;
  logic [15:0] w_pre_nxt;
  logic        w_wr_psc;
`endif

  function automatic logic [31:0] f_merge(
    input logic [31:0] old,
    input logic [31:0] d,
    input logic [3:0]  be
  );
    logic [31:0] res;
    res = old;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[i*8 +: 8] = d[i*8 +: 8];
    end
    return res;
  endfunction

  assign w_hit     = (bus.addr[31:4] == BASE_ADDR[31:4]);
  assign w_sel     = bus.addr[3:2];
  assign w_wr      = w_hit && (bus.byteen != 4'b0000);
  assign w_wr_ctrl = w_wr && (w_sel == 2'd0);
  assign w_wr_pre  = w_wr && (w_sel == 2'd1);
  assign w_en      = r_ctrl[0];
  // MODE 2/3 behave like one-shot
  assign w_mode1   = (r_ctrl[2:1] == 2'b01);
  assign w_pre_merged =
    f_merge(r_preset, bus.wdata, bus.byteen);
  assign w_unused  = ^bus.addr[1:0];

  assign irq = r_irq_flag & r_ctrl[3];

`ifdef TC_PRESCALE_EN
  assign w_wr_psc = w_wr && (w_sel == 2'd3);
  assign w_tick   = (r_pre_cnt == r_prescale);
`else
  assign w_tick   = 1'b1;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_fire      = 1'b0;
    w_exit1     = 1'b0;
`ifdef TC_PRESCALE_EN
    w_pre_nxt   = r_pre_cnt;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (w_en) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        w_count_nxt = r_preset;
        w_state_nxt = S_CNT;
`ifdef TC_PRESCALE_EN
        w_pre_nxt   = '0;
`endif
      end
      S_CNT: begin
        if (!w_en) begin
          w_state_nxt = S_IDLE;
        end else if (w_tick) begin
`ifdef TC_PRESCALE_EN
          w_pre_nxt = '0;
`endif
          // decrement only when non-zero, so COUNT never wraps
          if (r_count == '0) begin
            w_state_nxt = S_INT;
            w_fire      = 1'b1;
          end else begin
            w_count_nxt = r_count - 32'd1;
          end
        end else begin
`ifdef TC_PRESCALE_EN
          w_pre_nxt = r_pre_cnt + 16'd1;
`endif
        end
      end
      S_INT: begin
        w_state_nxt = S_IDLE;
        w_exit1     = w_mode1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ctrl   <= '0;
      r_preset <= '0;
    end else begin
      // a CPU write to CTRL overrides the one-shot EN auto-clear
      if (w_wr_ctrl) begin
        if (bus.byteen[0]) r_ctrl <= bus.wdata[3:0];
      end else if (w_fire && !w_mode1) begin
        r_ctrl[0] <= 1'b0;
      end
      if (w_wr_pre) r_preset <= w_pre_merged;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_irq_flag <= 1'b0;
    end else begin
      // entry into INT beats a same-cycle acknowledge
      if (w_fire) r_irq_flag <= 1'b1;
      else if (w_wr_ctrl || w_exit1) r_irq_flag <= 1'b0;
    end
  end

`ifdef TC_PRESCALE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prescale <= '0;
      r_pre_cnt  <= '0;
    end else begin
      r_pre_cnt <= w_pre_nxt;
      if (w_wr_psc) begin
        if (bus.byteen[0]) r_prescale[7:0]  <= bus.wdata[7:0];
        if (bus.byteen[1]) r_prescale[15:8] <= bus.wdata[15:8];
      end
    end
  end
`endif

  always_comb begin
    bus.rdata = '0;
    if (w_hit) begin
      unique case (w_sel)
        2'd0: bus.rdata = {28'd0, r_ctrl};
        2'd1: bus.rdata = r_preset;
        2'd2: bus.rdata = r_count;
        2'd3: begin
`ifdef TC_PRESCALE_EN
          bus.rdata = {16'd0, r_prescale};
`else
          bus.rdata = '0;
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tc_timer.sv
// tb_tc_timer: directed + random checks of tc_timer against an
// age-based behavioural model of a timer run.
module tb_tc_timer;

  localparam logic [31:0] BASE = 32'h0000_7F00;

  logic clk;
  logic reset;
  logic irq;

  tc_timer_if bus ();

  tc_timer #(.BASE_ADDR(BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // model state: visible registers plus "age" of the current run,
  // counted in edges since IDLE saw EN
  logic [3:0]  m_ctrl;
  logic [31:0] m_preset;
  logic [31:0] m_count;
  bit          m_flag;
  bit          m_run;
  longint      m_age;
  longint      m_p;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp,
               $time);
    end
  endtask

  function automatic logic [31:0] lane_merge(
    input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[i*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction

  task automatic model_reset();
    m_ctrl = '0; m_preset = '0; m_count = '0;
    m_flag = 0; m_run = 0; m_age = 0; m_p = 0;
  endtask

  task automatic model_edge();
    bit en, md1, fire, done, wr, wctrl;
    en    = m_ctrl[0];
    md1   = (m_ctrl[2:1] == 2'b01);
    fire  = 0;
    done  = 0;
    wr    = (bus.addr[31:4] == BASE[31:4]) && (bus.byteen != 0);
    wctrl = wr && (bus.addr[3:2] == 2'd0);
    if (!m_run) begin
      if (en) begin m_run = 1; m_age = 0; end
    end else begin
      m_age++;
      if (m_age == 1) begin
        m_p = longint'(m_preset);
        m_count = m_preset;
      end else if (m_age <= m_p + 2) begin
        if (!en) m_run = 0;
        else if (m_age == m_p + 2) fire = 1;
        else m_count = 32'(m_p - (m_age - 1));
      end else begin
        done = 1;
        m_run = 0;
      end
    end
    if (wctrl) begin
      if (bus.byteen[0]) m_ctrl = bus.wdata[3:0];
      m_flag = 0;
    end
    if (wr && bus.addr[3:2] == 2'd1)
      m_preset = lane_merge(m_preset, bus.wdata, bus.byteen);
    if (fire) begin
      m_flag = 1;
      if (!md1 && !wctrl) m_ctrl[0] = 1'b0;
    end
    if (done && md1) m_flag = 0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_reset();
      else model_edge();
    end
  end

  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    if (a[31:4] != BASE[31:4]) return 32'd0;
    case (a[3:2])
      2'd0:    return {28'd0, m_ctrl};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return 32'd0;
    endcase
  endfunction

  // compare process: every negedge once the model is initialised
  always @(negedge clk) begin
    if (chk_en) begin
      chk("rdata", bus.rdata, exp_rd(bus.addr));
      chk("irq", {31'd0, irq}, {31'd0, m_flag & m_ctrl[3]});
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] be,
                    input logic [31:0] d);
    bus.addr = a; bus.byteen = be; bus.wdata = d;
    tick();
    bus.byteen = 4'b0000;
  endtask

  task automatic peek(input logic [31:0] a, output logic [31:0] d);
    bus.addr = a; bus.byteen = 4'b0000;
    #1;
    d = bus.rdata;
  endtask

  logic [31:0] rd;
  logic [31:0] a, d;
  logic [3:0]  be;
  int          r, sel;

  initial begin
    reset = 1'b1;
    bus.addr = BASE + 32'h10; bus.byteen = 4'b0000; bus.wdata = '0;
    repeat (2) tick();
    reset = 1'b0;
    chk_en = 1'b1;
    tick();

    // reset values and miss behaviour
    peek(BASE + 0, rd); chk("rst_ctrl", rd, 32'h0);
    peek(BASE + 4, rd); chk("rst_preset", rd, 32'h0);
    peek(BASE + 8, rd); chk("rst_count", rd, 32'h0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    wr(BASE + 32'h10, 4'hF, 32'hFFFF_FFFF);
    peek(BASE + 32'h10, rd); chk("miss_rd", rd, 32'h0);
    peek(BASE + 0, rd); chk("miss_nowr", rd, 32'h0);

    // one-shot, PRESET=5
    wr(BASE + 4, 4'hF, 32'd5);
    wr(BASE + 0, 4'hF, 32'h9);
    repeat (2) tick();
    peek(BASE + 8, rd); chk("os_count_e2", rd, 32'd5);
    repeat (5) tick();
    peek(BASE + 8, rd); chk("os_count_e7", rd, 32'd0);
    chk("os_irq_e7", {31'd0, irq}, 32'd0);
    tick();
    chk("os_irq_e8", {31'd0, irq}, 32'd1);
    peek(BASE + 0, rd); chk("os_ctrl_en_clr", rd, 32'h8);
    repeat (3) tick();
    chk("os_irq_hold", {31'd0, irq}, 32'd1);
    wr(BASE + 0, 4'hF, 32'h8);
    chk("os_irq_ack", {31'd0, irq}, 32'd0);

    // auto-reload, PRESET=3: pulses after edges 6, 13, 20
    wr(BASE + 4, 4'hF, 32'd3);
    wr(BASE + 0, 4'hF, 32'hB);
    for (int i = 1; i <= 21; i++) begin
      tick();
      chk($sformatf("ar_irq_e%0d", i), {31'd0, irq},
          (i == 6 || i == 13 || i == 20) ? 32'd1 : 32'd0);
    end
    wr(BASE + 0, 4'hF, 32'h3);
    for (int i = 0; i < 14; i++) begin
      tick();
      chk("ar_masked", {31'd0, irq}, 32'd0);
    end
    wr(BASE + 0, 4'hF, 32'h0);
    repeat (4) tick();

    // byte lanes, read-only COUNT, reserved slot
    wr(BASE + 4, 4'hF, 32'h1111_1111);
    wr(BASE + 4, 4'b0010, 32'h0000_AB00);
    peek(BASE + 4, rd); chk("byte_lane", rd, 32'h1111_AB11);
    peek(BASE + 8, d);
    wr(BASE + 8, 4'hF, 32'hDEAD_BEEF);
    peek(BASE + 8, rd); chk("count_ro", rd, m_count);
    wr(BASE + 12, 4'hF, 32'hFFFF_FFFF);
    peek(BASE + 12, rd); chk("reserved_rd", rd, 32'h0);

    // reset in the middle of a long count
    wr(BASE + 4, 4'hF, 32'd100);
    wr(BASE + 0, 4'hF, 32'h9);
    repeat (10) tick();
    peek(BASE + 8, rd); chk("mid_count", rd, 32'd92);
    reset = 1'b1;
    #1;
    peek(BASE + 8, rd); chk("rst_mid_count", rd, 32'd0);
    chk("rst_mid_irq", {31'd0, irq}, 32'd0);
    tick();
    reset = 1'b0;
    repeat (5) tick();
    peek(BASE + 0, rd); chk("post_rst_ctrl", rd, 32'd0);
    wr(BASE + 4, 4'hF, 32'd2);
    repeat (6) tick();
    peek(BASE + 8, rd); chk("post_rst_idle", rd, 32'd0);
    wr(BASE + 0, 4'hF, 32'h9);
    repeat (5) tick();
    chk("post_rst_irq", {31'd0, irq}, 32'd1);
    wr(BASE + 0, 4'hF, 32'h0);

    // random traffic checked by the compare process
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(99));
      if (r == 0) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
      end else if (r < 30) begin
        sel = int'($urandom_range(3));
        a   = BASE + 32'(sel * 4);
        be  = 4'($urandom_range(15));
        if (sel == 1) d = 32'($urandom_range(12));
        else d = $urandom;
        if ($urandom_range(9) == 0) a = a ^ 32'h100;
        wr(a, be, d);
      end else begin
        a = BASE + 32'($urandom_range(3) * 4);
        if ($urandom_range(9) == 0) a = a ^ 32'h200;
        bus.addr = a;
        tick();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
